// File: rtl/bcd_pkg.sv
// Shared types, codes and sizing helper for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    localparam bcd_digit_t BCD_ERR   = 4'hE;
    localparam bcd_digit_t BCD_BLANK = 4'hF;

    // Decimal digits needed to hold any bin_w-bit unsigned value: ceil(bin_w*log10(2)).
    function automatic int bcd_digits_for(input int bin_w);
        return (bin_w * 301 + 999) / 1000;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_add3
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with valid/ready handshakes on both sides.
// Optional build macro BCD_BLANK_EN replaces leading-zero digits above digit 0 with the blank code.
module bcd_convert_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 7,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int INT_DIGITS = bcd_digits_for(BIN_W);
    localparam int SCR_W      = 4 * INT_DIGITS;
    localparam int OUT_W      = 4 * DIGITS;
    localparam int EXT_D      = (DIGITS > INT_DIGITS) ? DIGITS : INT_DIGITS;
    localparam int EXT_W      = 4 * EXT_D;
    localparam int CNT_W      = $clog2(BIN_W + 1);

    conv_state_t        state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BIN_W-1:0]   bin_q;
    logic [SCR_W-1:0]   scr_q;
    logic [OUT_W-1:0]   bcd_q;
    logic               ovf_q;
    logic               out_valid_q;
    logic               in_ready_q;

    logic [SCR_W-1:0]   adj;
    logic [SCR_W-1:0]   scr_d;
    logic [BIN_W-1:0]   bin_d;
    logic [EXT_W-1:0]   scr_ext;
    logic [OUT_W-1:0]   fmt_bcd_d;
    logic               fmt_ovf_d;

    genvar gi;
    generate
        for (gi = 0; gi < INT_DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .digit_i (scr_q[4*gi +: 4]),
                .digit_o (adj[4*gi +: 4])
            );
        end
    endgenerate

    // The top adjusted bit is always 0 with a correctly sized scratch, so recirculating it
    // into the vacated binary LSB is equivalent to shifting in zero.
    assign scr_d   = {adj[SCR_W-2:0], bin_q[BIN_W-1]};
    assign bin_d   = {bin_q[BIN_W-2:0], adj[SCR_W-1]};
    assign scr_ext = EXT_W'(scr_q);

`ifdef BCD_BLANK_EN
    logic lead;
`endif

    always_comb begin
        fmt_ovf_d = 1'b0;
        fmt_bcd_d = '0;
        for (int i = DIGITS; i < EXT_D; i++) begin
            if (scr_ext[4*i +: 4] != 4'd0) fmt_ovf_d = 1'b1;
        end
        for (int i = 0; i < DIGITS; i++) begin
            fmt_bcd_d[4*i +: 4] = scr_ext[4*i +: 4];
        end
`ifdef BCD_BLANK_EN
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && fmt_bcd_d[4*i +: 4] == 4'd0) fmt_bcd_d[4*i +: 4] = BCD_BLANK;
            else lead = 1'b0;
        end
`endif
        if (fmt_ovf_d) fmt_bcd_d = {DIGITS{BCD_ERR}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bin_q       <= '0;
            scr_q       <= '0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        bin_q      <= bin_in;
                        scr_q      <= '0;
                        cnt_q      <= CNT_W'(BIN_W);
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q != '0) begin
                        scr_q <= scr_d;
                        bin_q <= bin_d;
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        bcd_q       <= fmt_bcd_d;
                        ovf_q       <= fmt_ovf_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bcd_out   = bcd_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Self-checking bench for bcd_convert_seq: default, wide and 10-bit instances with a result scoreboard.
module tb_bcd_convert_seq;

`ifdef BCD_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [6:0]  a_bin = '0;
    logic        a_in_ready, a_out_valid, a_ovf;
    logic [7:0]  a_bcd;

    logic        w_in_valid = 1'b0, w_out_ready = 1'b0;
    logic [16:0] w_bin = '0;
    logic        b_in_ready, b_out_valid, b_ovf;
    logic [19:0] b_bcd;
    logic        c_in_ready, c_out_valid, c_ovf;
    logic [15:0] c_bcd;

    logic        d_in_valid = 1'b0, d_out_ready = 1'b0;
    logic [9:0]  d_bin = '0;
    logic        d_in_ready, d_out_valid, d_ovf;
    logic [11:0] d_bcd;

    bcd_convert_seq #(.BIN_W(7), .DIGITS(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .bin_in(a_bin),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .bcd_out(a_bcd), .overflow(a_ovf));

    bcd_convert_seq #(.BIN_W(17), .DIGITS(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(b_in_ready), .bin_in(w_bin),
        .out_valid(b_out_valid), .out_ready(w_out_ready), .bcd_out(b_bcd), .overflow(b_ovf));

    bcd_convert_seq #(.BIN_W(17), .DIGITS(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(c_in_ready), .bin_in(w_bin),
        .out_valid(c_out_valid), .out_ready(w_out_ready), .bcd_out(c_bcd), .overflow(c_ovf));

    bcd_convert_seq #(.BIN_W(10), .DIGITS(3)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready), .bin_in(d_bin),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .bcd_out(d_bcd), .overflow(d_ovf));

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
    } exp_t;
    exp_t sb_q[$];

    // Reference: decimal digit extraction by division, independent of the shift-add-3 algorithm.
    function automatic exp_t model(input int v, input int digits, input bit blank);
        exp_t e;
        int lim = 1;
        int x   = v;
        e.bcd = '0;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        e.ovf = (v >= lim);
        for (int i = 0; i < digits; i++) begin
            if (e.ovf) e.bcd[4*i +: 4] = 4'hE;
            else begin
                e.bcd[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        if (blank && !e.ovf) begin
            for (int i = digits - 1; i >= 1; i--) begin
                if (e.bcd[4*i +: 4] != 4'd0) break;
                e.bcd[4*i +: 4] = 4'hF;
            end
        end
        return e;
    endfunction

    task automatic conv_a(input int v, input int hold);
        exp_t e;
        int   lat;
        a_out_ready = (hold == 0);
        a_bin       = 7'(v);
        a_in_valid  = 1'b1;
        lat = 0;
        while (!a_in_ready && lat < 40) begin @(posedge clk); #1; lat++; end
        compared++;
        if (a_in_ready !== 1'b1) begin
            mismatched++; $display("FAIL a_accept_timeout v=%0d in_ready=%b required 1", v, a_in_ready);
        end
        sb_q.push_back(model(v, 2, BLANK));
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_bin      = 7'($urandom);
        compared++;
        if (a_in_ready !== 1'b0) begin
            mismatched++; $display("FAIL a_busy_ready v=%0d in_ready=%b required 0", v, a_in_ready);
        end
        lat = 0;
        while (!a_out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        compared++;
        if (lat !== 8) begin
            mismatched++; $display("FAIL a_latency v=%0d got %0d edges required 8", v, lat);
        end
        e = sb_q.pop_front();
        compared++;
        if (a_bcd !== e.bcd[7:0]) begin
            mismatched++; $display("FAIL a_bcd v=%0d got %h required %h", v, a_bcd, e.bcd[7:0]);
        end
        compared++;
        if (a_ovf !== e.ovf) begin
            mismatched++; $display("FAIL a_ovf v=%0d got %b required %b", v, a_ovf, e.ovf);
        end
        for (int h = 0; h < hold; h++) begin
            a_in_valid = 1'b1;
            a_bin      = 7'($urandom);
            @(posedge clk); #1;
            compared++;
            if (a_bcd !== e.bcd[7:0] || a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL a_hold v=%0d cyc=%0d bcd=%h valid=%b ready=%b required %h 1 0",
                         v, h, a_bcd, a_out_valid, a_in_ready, e.bcd[7:0]);
            end
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL a_release v=%0d valid=%b ready=%b required 0 1", v, a_out_valid, a_in_ready);
        end
    endtask

    task automatic conv_w(input int v);
        exp_t eb, ec;
        int   lat;
        w_out_ready = 1'b1;
        w_bin       = 17'(v);
        w_in_valid  = 1'b1;
        lat = 0;
        while (!(b_in_ready && c_in_ready) && lat < 60) begin @(posedge clk); #1; lat++; end
        sb_q.push_back(model(v, 5, BLANK));
        sb_q.push_back(model(v, 4, BLANK));
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        w_bin      = 17'($urandom);
        lat = 0;
        while (!b_out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
        compared++;
        if (lat !== 18 || c_out_valid !== 1'b1) begin
            mismatched++; $display("FAIL w_latency v=%0d got %0d edges c_valid=%b required 18 1", v, lat, c_out_valid);
        end
        eb = sb_q.pop_front();
        ec = sb_q.pop_front();
        compared++;
        if (b_bcd !== eb.bcd[19:0] || b_ovf !== eb.ovf) begin
            mismatched++; $display("FAIL b_result v=%0d got %h/%b required %h/%b", v, b_bcd, b_ovf, eb.bcd[19:0], eb.ovf);
        end
        compared++;
        if (c_bcd !== ec.bcd[15:0] || c_ovf !== ec.ovf) begin
            mismatched++; $display("FAIL c_result v=%0d got %h/%b required %h/%b", v, c_bcd, c_ovf, ec.bcd[15:0], ec.ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic conv_d(input int v);
        exp_t e;
        int   lat;
        d_out_ready = 1'b1;
        d_bin       = 10'(v);
        d_in_valid  = 1'b1;
        lat = 0;
        while (!d_in_ready && lat < 40) begin @(posedge clk); #1; lat++; end
        sb_q.push_back(model(v, 3, BLANK));
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        d_bin      = 10'($urandom);
        lat = 0;
        while (!d_out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        compared++;
        if (lat !== 11) begin
            mismatched++; $display("FAIL d_latency v=%0d got %0d edges required 11", v, lat);
        end
        e = sb_q.pop_front();
        compared++;
        if (d_bcd !== e.bcd[11:0] || d_ovf !== e.ovf) begin
            mismatched++; $display("FAIL d_result v=%0d got %h/%b required %h/%b", v, d_bcd, d_ovf, e.bcd[11:0], e.ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #10;
        compared++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_bcd !== 8'h00 || a_ovf !== 1'b0) begin
            mismatched++; $display("FAIL reset_a ready=%b valid=%b bcd=%h ovf=%b required 1 0 00 0",
                                   a_in_ready, a_out_valid, a_bcd, a_ovf);
        end
        compared++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_bcd !== 20'h0 || c_bcd !== 16'h0 ||
            d_bcd !== 12'h0 || d_ovf !== 1'b0 || c_ovf !== 1'b0) begin
            mismatched++; $display("FAIL reset_bcd b=%h c=%h d=%h b_ready=%b b_valid=%b required zeros 1 0",
                                   b_bcd, c_bcd, d_bcd, b_in_ready, b_out_valid);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        conv_a(59, 0);
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 128; v++) conv_a(v, 0);
    endtask

    task automatic test_hold();
        conv_a(42, 5);
    endtask

    task automatic test_abort();
        a_out_ready = 1'b1;
        a_bin       = 7'd100;
        a_in_valid  = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        compared++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0) begin
            mismatched++; $display("FAIL abort_busy ready=%b valid=%b required 0 0", a_in_ready, a_out_valid);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (a_out_valid !== 1'b0 || a_bcd !== 8'h00 || a_ovf !== 1'b0 || a_in_ready !== 1'b1) begin
            mismatched++; $display("FAIL abort_reset valid=%b bcd=%h ovf=%b ready=%b required 0 00 0 1",
                                   a_out_valid, a_bcd, a_ovf, a_in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        conv_a(7, 0);
    endtask

    task automatic test_wide();
        conv_w(86399);
        conv_w(10000);
        conv_w(9999);
        conv_w(131071);
    endtask

    task automatic test_small_digits();
        conv_d(5);
        conv_d(0);
        conv_d(205);
        conv_d(999);
        conv_d(1000);
        conv_d(1023);
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_hold();
        test_abort();
        test_wide();
        test_small_digits();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
